fmul_72bit_norm: RTL and testbench

- Back end of the 72-bit floating multiplier.
- Consumes the raw sign / exponent-sum / 120-bit fraction product / exception flags produced by the multiplier calculation stage.
- Normalizes, rounds to nearest-even, applies special-value and range handling, and emits the packed 72-bit result: sign[71], exp[70:60] (bias 1023), fraction[59:0].
- 2-cycle pipeline using the same REQ/VALID/BUSY stall handshake as the calculation stage.

---
 rtl/fmul_72bit_norm.sv | 188 ++++++++++++++++++
 tb/tb_fmul_72bit_norm.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fmul_72bit_norm.sv
// Back end of the 72-bit float multiplier: normalize, round-nearest-even,
// special-value and range handling, pack as sign[71] exp[70:60] fract[59:0].
// Ports: iCLOCK/iRESET (async, high)/iRESET_SYNC; iDATA_REQ/oDATA_BUSY in;
// iDATA_SIGN/EXP/FRACT/EXCEPT_*; oDATA_VALID/iDATA_BUSY out; oDATA_DATA/FLAG_*.
module fmul_72bit_norm #(
  parameter int          P_BIAS       = 1023,
  parameter logic [59:0] P_QNAN_FRACT = 60'h800000000000000
) (
  input  logic         iCLOCK,
  input  logic         iRESET,
  input  logic         iRESET_SYNC,
  input  logic         iDATA_REQ,
  output logic         oDATA_BUSY,
  input  logic         iDATA_SIGN,
  input  logic [12:0]  iDATA_EXP,
  input  logic [119:0] iDATA_FRACT,
  input  logic         iDATA_EXCEPT_EXP_A0,
  input  logic         iDATA_EXCEPT_EXP_B0,
  input  logic         iDATA_EXCEPT_EXP_A1,
  input  logic         iDATA_EXCEPT_EXP_B1,
  input  logic         iDATA_EXCEPT_FRACT_A0,
  input  logic         iDATA_EXCEPT_FRACT_B0,
  output logic         oDATA_VALID,
  input  logic         iDATA_BUSY,
  output logic [71:0]  oDATA_DATA,
  output logic         oDATA_FLAG_INVALID,
  output logic         oDATA_FLAG_OVERFLOW,
  output logic         oDATA_FLAG_UNDERFLOW,
  output logic         oDATA_FLAG_INEXACT
);

  // Largest biased exponent value; reaching it means overflow to Inf.
  localparam logic [13:0] LP_EMAX = 14'(2 * P_BIAS + 1);

  logic        ld;
  assign ld         = ~iDATA_BUSY;
  assign oDATA_BUSY = iDATA_BUSY;

  // Stage 1: classify / normalize
  logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
  logic        inf_zero, any_nan, any_inf, any_zero, n;
  logic        s1_special_d, s1_invalid_d, s1_guard_d, s1_sticky_d;
  logic [71:0] s1_spec_d;
  logic [59:0] s1_mant_d;
  logic [13:0] s1_e1_d;

  logic        s1_valid_q, s1_sign_q, s1_special_q, s1_invalid_q;
  logic        s1_guard_q, s1_sticky_q;
  logic [71:0] s1_spec_q;
  logic [59:0] s1_mant_q;
  logic [13:0] s1_e1_q;

  assign nan_a  = iDATA_EXCEPT_EXP_A1 & ~iDATA_EXCEPT_FRACT_A0;
  assign nan_b  = iDATA_EXCEPT_EXP_B1 & ~iDATA_EXCEPT_FRACT_B0;
  assign inf_a  = iDATA_EXCEPT_EXP_A1 & iDATA_EXCEPT_FRACT_A0;
  assign inf_b  = iDATA_EXCEPT_EXP_B1 & iDATA_EXCEPT_FRACT_B0;
  // Denormal operands are flushed to zero.
  assign zero_a = iDATA_EXCEPT_EXP_A0;
  assign zero_b = iDATA_EXCEPT_EXP_B0;

  assign inf_zero = (inf_a & zero_b) | (inf_b & zero_a);
  assign any_nan  = nan_a | nan_b;
  assign any_inf  = inf_a | inf_b;
  assign any_zero = zero_a | zero_b;
  assign n        = iDATA_FRACT[119];

  always_comb begin
    s1_special_d = any_nan | any_inf | any_zero;
    s1_invalid_d = inf_zero;
    s1_spec_d    = {iDATA_SIGN, 71'd0};
    if (any_nan | inf_zero)
      s1_spec_d = {1'b0, 11'h7FF, P_QNAN_FRACT};
    else if (any_inf)
      s1_spec_d = {iDATA_SIGN, 11'h7FF, 60'd0};
    if (n) begin
      s1_mant_d   = iDATA_FRACT[118:59];
      s1_guard_d  = iDATA_FRACT[58];
      s1_sticky_d = |iDATA_FRACT[57:0];
    end else begin
      s1_mant_d   = iDATA_FRACT[117:58];
      s1_guard_d  = iDATA_FRACT[57];
      s1_sticky_d = |iDATA_FRACT[56:0];
    end
    s1_e1_d = {iDATA_EXP[12], iDATA_EXP} + {13'd0, n};
  end

  // Stage 2: round / pack
  logic [60:0] sum;
  logic        inc, carry, ovf, unf;
  logic [59:0] mant2;
  logic [13:0] e2;
  logic [71:0] s2_data_d;
  logic        s2_inv_d, s2_ovf_d, s2_unf_d, s2_inx_d;

  logic        s2_valid_q;
  logic [71:0] s2_data_q;
  logic        s2_inv_q, s2_ovf_q, s2_unf_q, s2_inx_q;

  assign inc   = s1_guard_q & (s1_sticky_q | s1_mant_q[0]);
  assign sum   = {1'b0, s1_mant_q} + {60'd0, inc};
  assign carry = sum[60];
  assign mant2 = carry ? 60'd0 : sum[59:0];
  assign e2    = s1_e1_q + {13'd0, carry};
  assign ovf   = ~e2[13] & (e2 >= LP_EMAX);
  assign unf   = e2[13] | (e2 == 14'd0);

  always_comb begin
    s2_data_d = {s1_sign_q, e2[10:0], mant2};
    s2_inv_d  = 1'b0;
    s2_ovf_d  = 1'b0;
    s2_unf_d  = 1'b0;
    s2_inx_d  = s1_guard_q | s1_sticky_q;
    if (s1_special_q) begin
      s2_data_d = s1_spec_q;
      s2_inv_d  = s1_invalid_q;
      s2_inx_d  = 1'b0;
    end else if (ovf) begin
      s2_data_d = {s1_sign_q, 11'h7FF, 60'd0};
      s2_ovf_d  = 1'b1;
      s2_inx_d  = 1'b1;
    end else if (unf) begin
      // Normal-path mantissa always has its hidden one, so always inexact.
      s2_data_d = {s1_sign_q, 71'd0};
      s2_unf_d  = 1'b1;
      s2_inx_d  = 1'b1;
    end
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      s1_valid_q   <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_special_q <= 1'b0;
      s1_invalid_q <= 1'b0;
      s1_guard_q   <= 1'b0;
      s1_sticky_q  <= 1'b0;
      s1_spec_q    <= '0;
      s1_mant_q    <= '0;
      s1_e1_q      <= '0;
      s2_valid_q   <= 1'b0;
      s2_data_q    <= '0;
      s2_inv_q     <= 1'b0;
      s2_ovf_q     <= 1'b0;
      s2_unf_q     <= 1'b0;
      s2_inx_q     <= 1'b0;
    end else if (iRESET_SYNC) begin
      s1_valid_q   <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_special_q <= 1'b0;
      s1_invalid_q <= 1'b0;
      s1_guard_q   <= 1'b0;
      s1_sticky_q  <= 1'b0;
      s1_spec_q    <= '0;
      s1_mant_q    <= '0;
      s1_e1_q      <= '0;
      s2_valid_q   <= 1'b0;
      s2_data_q    <= '0;
      s2_inv_q     <= 1'b0;
      s2_ovf_q     <= 1'b0;
      s2_unf_q     <= 1'b0;
      s2_inx_q     <= 1'b0;
    end else if (ld) begin
      s1_valid_q   <= iDATA_REQ;
      s1_sign_q    <= iDATA_SIGN;
      s1_special_q <= s1_special_d;
      s1_invalid_q <= s1_invalid_d;
      s1_guard_q   <= s1_guard_d;
      s1_sticky_q  <= s1_sticky_d;
      s1_spec_q    <= s1_spec_d;
      s1_mant_q    <= s1_mant_d;
      s1_e1_q      <= s1_e1_d;
      s2_valid_q   <= s1_valid_q;
      s2_data_q    <= s2_data_d;
      s2_inv_q     <= s2_inv_d;
      s2_ovf_q     <= s2_ovf_d;
      s2_unf_q     <= s2_unf_d;
      s2_inx_q     <= s2_inx_d;
    end
  end

  assign oDATA_VALID          = s2_valid_q;
  assign oDATA_DATA           = s2_data_q;
  assign oDATA_FLAG_INVALID   = s2_inv_q;
  assign oDATA_FLAG_OVERFLOW  = s2_ovf_q;
  assign oDATA_FLAG_UNDERFLOW = s2_unf_q;
  assign oDATA_FLAG_INEXACT   = s2_inx_q;

endmodule

// File: tb/tb_fmul_72bit_norm.sv
// Self-checking bench for fmul_72bit_norm: directed vectors, stall, resets.
// Expected results are queued at drive time and popped on output transfer.
module tb_fmul_72bit_norm;

  logic         iCLOCK = 1'b0;
  logic         iRESET, iRESET_SYNC, iDATA_REQ, iDATA_BUSY;
  logic         iDATA_SIGN;
  logic [12:0]  iDATA_EXP;
  logic [119:0] iDATA_FRACT;
  logic         ea0, eb0, ea1, eb1, fa0, fb0;
  logic         oDATA_BUSY, oDATA_VALID;
  logic [71:0]  oDATA_DATA;
  logic         f_inv, f_ovf, f_unf, f_inx;

  fmul_72bit_norm dut (
    .iCLOCK(iCLOCK), .iRESET(iRESET), .iRESET_SYNC(iRESET_SYNC),
    .iDATA_REQ(iDATA_REQ), .oDATA_BUSY(oDATA_BUSY),
    .iDATA_SIGN(iDATA_SIGN), .iDATA_EXP(iDATA_EXP),
    .iDATA_FRACT(iDATA_FRACT),
    .iDATA_EXCEPT_EXP_A0(ea0), .iDATA_EXCEPT_EXP_B0(eb0),
    .iDATA_EXCEPT_EXP_A1(ea1), .iDATA_EXCEPT_EXP_B1(eb1),
    .iDATA_EXCEPT_FRACT_A0(fa0), .iDATA_EXCEPT_FRACT_B0(fb0),
    .oDATA_VALID(oDATA_VALID), .iDATA_BUSY(iDATA_BUSY),
    .oDATA_DATA(oDATA_DATA),
    .oDATA_FLAG_INVALID(f_inv), .oDATA_FLAG_OVERFLOW(f_ovf),
    .oDATA_FLAG_UNDERFLOW(f_unf), .oDATA_FLAG_INEXACT(f_inx)
  );

  always #5 iCLOCK = ~iCLOCK;

  typedef struct packed {
    logic         s;
    logic [12:0]  e;
    logic [119:0] fr;
    logic [5:0]   x;   // {a0,b0,a1,b1,fa0,fb0}
    logic [71:0]  d;
    logic [3:0]   f;   // {inv,ovf,unf,inx}
  } vec_t;

  typedef struct packed {
    logic [71:0] d;
    logic [3:0]  f;
    logic [7:0]  id;
  } exp_t;

  vec_t tv [11];
  exp_t sb [$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(string tag, logic [71:0] obs, logic [71:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic vec_t mk(logic s, logic [12:0] e, logic [119:0] fr,
                              logic [5:0] x, logic [71:0] d, logic [3:0] f);
    vec_t v;
    v.s = s; v.e = e; v.fr = fr; v.x = x; v.d = d; v.f = f;
    return v;
  endfunction

  task automatic apply(int i);
    iDATA_SIGN  = tv[i].s;
    iDATA_EXP   = tv[i].e;
    iDATA_FRACT = tv[i].fr;
    {ea0, eb0, ea1, eb1, fa0, fb0} = tv[i].x;
    iDATA_REQ   = 1'b1;
  endtask

  task automatic drive(int i);
    apply(i);
    if (!iDATA_BUSY) sb.push_back({tv[i].d, tv[i].f, 8'(i)});
    @(posedge iCLOCK); #1;
    iDATA_REQ = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge iCLOCK);
    #1;
    n_chk++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL drain observed=%0d pending expected=0", sb.size());
    end
  endtask

  // Output monitor: compare head of scoreboard; pop only on transfer.
  always @(negedge iCLOCK) begin
    if (!iRESET && !iRESET_SYNC && oDATA_VALID) begin
      chk("busy_mirror", 72'(oDATA_BUSY), 72'(iDATA_BUSY));
      n_chk++;
      assert (sb.size() > 0) else begin
        n_fail++;
        $error("FAIL spurious observed=%h expected=none", oDATA_DATA);
      end
      if (sb.size() > 0) begin
        chk($sformatf("data#%0d", sb[0].id), oDATA_DATA, sb[0].d);
        chk($sformatf("flags#%0d", sb[0].id),
            72'({f_inv, f_ovf, f_unf, f_inx}), 72'(sb[0].f));
        if (!iDATA_BUSY) void'(sb.pop_front());
      end
    end
  end

  initial begin
    logic [119:0] cf;
    cf = (120'd1 << 118) | (((120'd1 << 61) - 120'd1) << 57);
    tv[0]  = mk(0, 13'd1023, 120'd1 << 118, 6'b000000,
                72'h3FF000000000000000, 4'b0000);
    tv[1]  = mk(0, 13'd1023, (120'd1 << 119) | (120'd1 << 116), 6'b000000,
                72'h400200000000000000, 4'b0000);
    tv[2]  = mk(0, 13'd1023, (120'd1 << 118) | (120'd1 << 57), 6'b000000,
                72'h3FF000000000000000, 4'b0001);
    tv[3]  = mk(0, 13'd1023,
                (120'd1 << 118) | (120'd1 << 58) | (120'd1 << 57), 6'b000000,
                72'h3FF000000000000002, 4'b0001);
    tv[4]  = mk(0, 13'd2046, 120'd1 << 119, 6'b000000,
                72'h7FF000000000000000, 4'b0101);
    tv[5]  = mk(0, 13'h1FFB, 120'd1 << 119, 6'b000000,
                72'h000000000000000000, 4'b0011);
    tv[6]  = mk(0, 13'd1023, 120'd1 << 118, 6'b011010,
                72'h7FF800000000000000, 4'b1000);
    tv[7]  = mk(1, 13'd1023, 120'd1 << 118, 6'b001010,
                72'hFFF000000000000000, 4'b0000);
    tv[8]  = mk(0, 13'd1023, cf, 6'b000000,
                72'h400000000000000000, 4'b0001);
    tv[9]  = mk(0, 13'd1023, 120'd1 << 118, 6'b001000,
                72'h7FF800000000000000, 4'b0000);
    tv[10] = mk(1, 13'd1023, 120'd1 << 118, 6'b010000,
                72'h800000000000000000, 4'b0000);

    iRESET = 1'b1; iRESET_SYNC = 1'b0; iDATA_REQ = 1'b0; iDATA_BUSY = 1'b0;
    iDATA_SIGN = 1'b0; iDATA_EXP = '0; iDATA_FRACT = '0;
    {ea0, eb0, ea1, eb1, fa0, fb0} = '0;
    repeat (2) @(posedge iCLOCK);
    #1;
    chk("rst_valid", 72'(oDATA_VALID), 72'd0);
    chk("rst_data", oDATA_DATA, 72'd0);
    chk("rst_flags", 72'({f_inv, f_ovf, f_unf, f_inx}), 72'd0);
    iRESET = 1'b0;
    @(posedge iCLOCK); #1;

    // Directed vectors back to back.
    for (int i = 0; i < 11; i++) drive(i);
    drain();

    // Stream with a 3-cycle downstream stall in the middle.
    drive(0);
    drive(1);
    iDATA_BUSY = 1'b1;
    apply(2);
    repeat (3) begin
      @(posedge iCLOCK); #1;
    end
    iDATA_BUSY = 1'b0;
    drive(2);
    drive(3);
    drain();

    // Asynchronous reset with two results in flight.
    drive(0);
    drive(1);
    iRESET = 1'b1;
    sb.delete();
    #1;
    chk("arst_valid", 72'(oDATA_VALID), 72'd0);
    chk("arst_data", oDATA_DATA, 72'd0);
    @(posedge iCLOCK); #1;
    chk("arst_valid_next", 72'(oDATA_VALID), 72'd0);
    iRESET = 1'b0;

    // Synchronous clear with one result in stage 1.
    drive(1);
    iRESET_SYNC = 1'b1;
    sb.delete();
    @(posedge iCLOCK); #1;
    iRESET_SYNC = 1'b0;
    chk("srst_valid", 72'(oDATA_VALID), 72'd0);
    chk("srst_data", oDATA_DATA, 72'd0);
    @(posedge iCLOCK); #1;
    chk("srst_valid_next", 72'(oDATA_VALID), 72'd0);

    // Pipeline recovers after clear.
    drive(7);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
